// File: rtl/icache_dm_if.sv
// Fetch-port and memory-port bundle for icache_dm.
// The slave modport is the cache itself; the master modport is everything
// around it (core fetch stage plus main memory), so it drives pcF, flush and
// the memory response and observes the instruction and the memory request.
interface icache_dm_if;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic        stallF;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output pcF, flush, mem_ready, mem_rdata,
        input  instrF, stallF, mem_req, mem_addr
    );

    modport slave (
        input  pcF, flush, mem_ready, mem_rdata,
        output instrF, stallF, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache.
// Hits return the instruction combinationally in the same cycle. A miss costs
// one lookup cycle and then refills the whole line, one word per memory
// handshake, from a base address latched at the miss.
// Optional build macro ICACHE_STATS_EN adds free-running hit/miss counters.
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    icache_dm_if.slave  bus
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int LW = 30 - OW;   // line address width (pcF[31:OW+2])
    localparam int TW = LW - IW;   // tag width

    typedef enum logic {IDLE, REFILL} state_e;

    state_e           state_q, state_d;
    logic [OW-1:0]    k_q, k_d;
    logic [LW-1:0]    base_q, base_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic             mem_req_q, mem_req_d;

    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];

    // Lookup fields of the current fetch address.
    logic [LW-1:0]    pc_line;
    logic [OW-1:0]    pc_word;
    logic [IW-1:0]    pc_index;
    logic [TW-1:0]    pc_tag;

    // Fields of the line being refilled, taken from the latched base.
    logic [IW-1:0]    fill_index;
    logic [TW-1:0]    fill_tag;

    logic             hit;
    logic             refill_wr;
    logic             refill_last;

    assign pc_line    = bus.pcF[31:OW+2];
    assign pc_word    = bus.pcF[OW+1:2];
    assign pc_index   = pc_line[IW-1:0];
    assign pc_tag     = pc_line[LW-1:IW];

    assign fill_index = base_q[IW-1:0];
    assign fill_tag   = base_q[LW-1:IW];

    // A lookup is only trusted in IDLE; during a refill the line is in flux.
    assign hit = (state_q == IDLE) && valid_q[pc_index] && (tag_q[pc_index] == pc_tag);

    assign bus.instrF   = hit ? data_q[pc_index][pc_word] : 32'h0;
    assign bus.stallF   = !hit;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = {base_q, k_q, 2'b00};

    // flush wins over any beat arriving in the same cycle, so an aborted
    // refill never writes or validates anything.
    assign refill_wr   = (state_q == REFILL) && bus.mem_ready && !bus.flush;
    assign refill_last = refill_wr && (k_q == '1);

    // Next-state logic for the lookup/refill controller and the valid bits.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                if (!hit) begin
                    base_d            = pc_line;
                    k_d               = '0;
                    state_d           = REFILL;
                    // The victim line is about to be overwritten word by word.
                    valid_d[pc_index] = 1'b0;
                end
            end
            REFILL: begin
                if (bus.flush) begin
                    k_d     = '0;
                    state_d = IDLE;
                end else if (bus.mem_ready) begin
                    k_d = k_q + OW'(1);
                    if (refill_last) begin
                        valid_d[fill_index] = 1'b1;
                        state_d             = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush) begin
            valid_d = '0;
        end

        mem_req_d = (state_d == REFILL);
    end

    // Controller state, refill pointer, valid bits and the registered request.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            base_q    <= '0;
            valid_q   <= '0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            base_q    <= base_d;
            valid_q   <= valid_d;
            mem_req_q <= mem_req_d;
        end
    end

    // Tag and data arrays: written only by the refill path.
    always_ff @(posedge clk) begin
        // NOTE: the arrays carry no reset so they can map onto RAM; the
        // valid bits alone decide whether their contents are visible.
        if (refill_wr) begin
            data_q[fill_index][k_q] <= bus.mem_rdata;
        end
        if (refill_last) begin
            tag_q[fill_index] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Hit/miss statistics; wrap naturally and ignore flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == IDLE) && (state_d == REFILL)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm (LINES=16, WORDS=4).
// Memory model returns addr ^ 32'hA5A5_0000 and can insert wait states.
module tb_icache_dm;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   wait_states = 0;
    int   wcnt = 0;

    logic [31:0] hit_pcs [3] = '{32'h4C, 32'h44, 32'h48};

    icache_dm_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_dm #(
        .LINES (16),
        .WORDS (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef ICACHE_STATS_EN
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Memory: answers after wait_states idle request cycles.
    assign bus.mem_ready = bus.mem_req && (wcnt >= wait_states);
    assign bus.mem_rdata = bus.mem_addr ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ready) wcnt <= 0;
        else                               wcnt <= wcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present pc and follow the fetch until it hits; checks every request
    // address, the stall count and the returned instruction.
    task automatic run_fetch(input string name, input logic [31:0] pc, input int exp_stall);
        int          stalls = 0;
        int          words = 0;
        bit          done = 1'b0;
        logic [31:0] base;
        base = pc & 32'hFFFF_FFF0;
        bus.pcF = pc;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!bus.stallF) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (bus.mem_req) begin
                    check({name, "_addr"}, bus.mem_addr, base + 32'(4 * words));
                    if (bus.mem_ready) words++;
                end
            end
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_stall"}, 32'(stalls), 32'(exp_stall));
        check({name, "_instr"}, bus.instrF, pc ^ 32'hA5A5_0000);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        bus.pcF   = 32'h40;
        bus.flush = 1'b0;
        #2;
        check("rst_stall", 32'(bus.stallF), 32'd1);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_instr", bus.instrF, 32'h0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        tick();
        tick();
        reset = 1'b1;

        // Cold miss, zero-wait memory.
        run_fetch("cold", 32'h40, 5);
`ifdef ICACHE_STATS_EN
        check("cold_miss_cnt", miss_cnt, 32'd1);
`endif

        // Same-cycle hits within the filled line.
        for (int i = 0; i < 3; i++) begin
            bus.pcF = hit_pcs[i];
            @(negedge clk);
            check("hit_instr", bus.instrF, hit_pcs[i] ^ 32'hA5A5_0000);
            check("hit_stall", 32'(bus.stallF), 32'd0);
            check("hit_req", 32'(bus.mem_req), 32'd0);
            tick();
        end

        // Conflict miss on the same index, then the evicted line misses again
        // against a memory that answers every third cycle.
        run_fetch("conflict", 32'h140, 5);
        wait_states = 2;
        run_fetch("wait", 32'h40, 13);
        wait_states = 0;

        // Flush while idle: the current hit still returns, next cycle misses.
        bus.flush = 1'b1;
        @(negedge clk);
        check("fl_idle_hit", 32'(bus.stallF), 32'd0);
        tick();
        bus.flush = 1'b0;
        check("fl_idle_miss", 32'(bus.stallF), 32'd1);

        // Flush after the second beat aborts the refill.
        tick();
        @(negedge clk);
        check("abort_addr0", bus.mem_addr, 32'h40);
        tick();
        @(negedge clk);
        check("abort_addr1", bus.mem_addr, 32'h44);
        tick();
        bus.flush = 1'b1;
        @(negedge clk);
        check("abort_req_hi", 32'(bus.mem_req), 32'd1);
        tick();
        bus.flush = 1'b0;
        check("abort_req_lo", 32'(bus.mem_req), 32'd0);
        check("abort_stall", 32'(bus.stallF), 32'd1);
        run_fetch("refetch", 32'h40, 5);

        // Flush coinciding with the final beat: line must stay invalid.
        bus.pcF = 32'h80;
        repeat (4) tick();
        bus.flush = 1'b1;
        @(negedge clk);
        check("last_ready", 32'(bus.mem_ready), 32'd1);
        check("last_addr", bus.mem_addr, 32'h8C);
        tick();
        bus.flush = 1'b0;
        check("last_stall", 32'(bus.stallF), 32'd1);
        check("last_req", 32'(bus.mem_req), 32'd0);
        run_fetch("last_refetch", 32'h80, 5);

        // Reset in the middle of a slow refill.
        wait_states = 2;
        bus.pcF = 32'hC0;
        tick();
        tick();
        check("rr_pre_req", 32'(bus.mem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("rr_req", 32'(bus.mem_req), 32'd0);
        check("rr_stall", 32'(bus.stallF), 32'd1);
        check("rr_addr", bus.mem_addr, 32'h0);
`ifdef ICACHE_STATS_EN
        check("rr_hit_cnt", hit_cnt, 32'd0);
        check("rr_miss_cnt", miss_cnt, 32'd0);
`endif
        tick();
        reset = 1'b1;
        wait_states = 0;
        run_fetch("post_rst_c0", 32'hC0, 5);
        run_fetch("post_rst_40", 32'h40, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
